// File: rtl/hf_pkg.sv
// Shared types and constants for the HF SSP transmit path.
package hf_pkg;

  localparam int unsigned SSP_BYTE_W       = 8;
  localparam int unsigned CLK_DIV_HALF_DEF = 4;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } ssp_state_e;

endpackage

// File: rtl/hf_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; a pop in the same cycle frees a slot for a push.
module hf_byte_fifo
  import hf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  pck0,
  input  logic                  rst,
  input  logic                  push,
  input  logic [SSP_BYTE_W-1:0] push_data,
  input  logic                  pop,
  output logic [SSP_BYTE_W-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic                  push_ok,
  output logic [PW-1:0]         level
);

  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]         wptr_q, rptr_q;
  logic [SSP_BYTE_W-1:0] mem_q [FIFO_DEPTH];
  logic                  pop_ok;

  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    level    = wptr_q - rptr_q;
    pop_data = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge pck0) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hf_ssp_tx.sv
// SSP byte serializer (FPGA to ARM): clock divider, IDLE/SHIFT FSM and MSB-first shifter.
// Define HF_SSP_TX_DROP_CNT_EN to add the saturating drop_cnt output.
module hf_ssp_tx
  import hf_pkg::*;
#(
  parameter int unsigned CLK_DIV_HALF = CLK_DIV_HALF_DEF,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  pck0,
  input  logic                  rst,
  input  logic [SSP_BYTE_W-1:0] tx_data,
  input  logic                  tx_strobe,
  output logic                  ssp_clk,
  output logic                  ssp_frame,
  output logic                  ssp_din,
  output logic [LW-1:0]         fifo_level,
  output logic                  busy
`ifdef HF_SSP_TX_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int unsigned DW = $clog2(CLK_DIV_HALF);

  logic [DW-1:0]         div_cnt_q;
  logic                  ssp_clk_q;
  logic                  div_term, rise_evt;

  ssp_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [SSP_BYTE_W-1:0] shreg_q, shreg_d;
  logic                  ssp_din_q, ssp_din_d;
  logic                  ssp_frame_q, ssp_frame_d;
  logic                  busy_q, busy_d;

  logic                  fifo_pop, fifo_full, fifo_empty, fifo_push_ok;
  logic [SSP_BYTE_W-1:0] fifo_data;
  logic [LW-1:0]         level_next;

  hf_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .pck0     (pck0),
    .rst      (rst),
    .push     (tx_strobe),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .push_ok  (fifo_push_ok),
    .level    (fifo_level)
  );

  assign div_term = (div_cnt_q == DW'(CLK_DIV_HALF - 1));
  assign rise_evt = div_term && !ssp_clk_q;

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      ssp_clk_q <= 1'b0;
    end else if (div_term) begin
      div_cnt_q <= '0;
      ssp_clk_q <= ~ssp_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ssp_din_d   = ssp_din_q;
    ssp_frame_d = ssp_frame_q;
    fifo_pop    = 1'b0;
    if (rise_evt) begin
      if (state_q == StShift && bit_cnt_q != 3'd7) begin
        shreg_d     = shreg_q << 1;
        ssp_din_d   = shreg_q[SSP_BYTE_W-2];
        ssp_frame_d = 1'b0;
        bit_cnt_d   = bit_cnt_q + 3'd1;
      end else if (!fifo_empty) begin
        // Idle or last bit done: next byte starts on this rise, no gap clock.
        fifo_pop    = 1'b1;
        shreg_d     = fifo_data;
        ssp_din_d   = fifo_data[SSP_BYTE_W-1];
        ssp_frame_d = 1'b1;
        bit_cnt_d   = 3'd0;
        state_d     = StShift;
      end else begin
        ssp_din_d   = 1'b0;
        ssp_frame_d = 1'b0;
        state_d     = StIdle;
      end
    end
    level_next = fifo_level + LW'(fifo_push_ok) - LW'(fifo_pop);
    busy_d     = (state_d == StShift) || (level_next != '0);
  end

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= '0;
      ssp_din_q   <= 1'b0;
      ssp_frame_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ssp_din_q   <= ssp_din_d;
      ssp_frame_q <= ssp_frame_d;
      busy_q      <= busy_d;
    end
  end

`ifdef HF_SSP_TX_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else if (tx_strobe && !fifo_push_ok && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign ssp_clk   = ssp_clk_q;
  assign ssp_frame = ssp_frame_q;
  assign ssp_din   = ssp_din_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_hf_ssp_tx.sv
// Scoreboard bench for hf_ssp_tx: queue-based reference model plus an independent wire monitor.
module tb_hf_ssp_tx;

  localparam int H  = 4;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          pck0 = 1'b0;
  logic          rst = 1'b1;
  logic          tx_strobe = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          ssp_clk, ssp_frame, ssp_din, busy;
  logic [LW-1:0] fifo_level;
`ifdef HF_SSP_TX_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  hf_ssp_tx #(
    .CLK_DIV_HALF(H),
    .FIFO_DEPTH  (D)
  ) dut (
    .pck0      (pck0),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_strobe (tx_strobe),
    .ssp_clk   (ssp_clk),
    .ssp_frame (ssp_frame),
    .ssp_din   (ssp_din),
    .fifo_level(fifo_level),
    .busy      (busy)
`ifdef HF_SSP_TX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 pck0 = ~pck0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes waiting, bytes on the wire (scoreboard), line activity.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  int         edge_n = 0;
  bit         on_wire = 0;
  int         bits_sent = 0;
  int         drops = 0;

  initial forever begin
    @(posedge pck0);
    if (rst) begin
      mq.delete();
      sb.delete();
      edge_n    = 0;
      on_wire   = 0;
      bits_sent = 0;
      drops     = 0;
    end else begin : model_step
      bit popped;
      popped = 0;
      edge_n++;
      // ssp_clk rises on every (2k+1)*H-th pck0 edge after reset release.
      if (edge_n % (2 * H) == H) begin
        if (on_wire && bits_sent < 8) begin
          bits_sent++;
        end else if (mq.size() > 0) begin
          sb.push_back(mq.pop_front());
          on_wire   = 1;
          bits_sent = 1;
          popped    = 1;
        end else begin
          on_wire = 0;
        end
      end
      if (tx_strobe) begin
        if (mq.size() < D || popped) mq.push_back(tx_data);
        else if (drops < 255) drops++;
      end
    end
  end

  // Monitor: sample on the falling pck0 edge, reassemble bytes from the wire.
  logic       prev_clk = 0, prev_din = 0, prev_frame = 0;
  int         cnt = 0, period = 0, rises_seen = 0;
  logic [7:0] acc = 8'h00;

  initial forever begin
    @(negedge pck0);
    if (rst) begin
      check("rst_ssp_clk", ssp_clk, 0);
      check("rst_frame", ssp_frame, 0);
      check("rst_din", ssp_din, 0);
      check("rst_level", fifo_level, 0);
      check("rst_busy", busy, 0);
      cnt = 0;
      period = 0;
      rises_seen = 0;
    end else begin
      period++;
      if (!prev_clk && ssp_clk) begin
        if (rises_seen > 0) check("clk_period", period, 2 * H);
        rises_seen++;
        period = 0;
        if (ssp_frame) begin
          if (cnt != 0) check("frame_spacing", cnt, 8);
          check("frame_expected", int'(sb.size() > 0), 1);
          cnt = 1;
          acc = {7'b0, ssp_din};
        end else if (cnt >= 1 && cnt <= 7) begin
          acc = {acc[6:0], ssp_din};
          cnt++;
          if (cnt == 8) begin
            check("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) check("byte", acc, sb.pop_front());
          end
        end else begin
          check("idle_din", ssp_din, 0);
          check("no_gap", sb.size(), 0);
          cnt = 0;
        end
      end else begin
        check("din_stable", ssp_din, prev_din);
        check("frame_stable", ssp_frame, prev_frame);
      end
      check("fifo_level", fifo_level, mq.size());
      check("busy", busy, int'(on_wire || mq.size() > 0));
`ifdef HF_SSP_TX_DROP_CNT_EN
      check("drop_cnt", drop_cnt, drops);
`endif
    end
    prev_clk   = ssp_clk;
    prev_din   = ssp_din;
    prev_frame = ssp_frame;
  end

  task automatic cyc(input bit s, input logic [7:0] d);
    @(posedge pck0);
    #2;
    tx_strobe = s;
    tx_data   = d;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((on_wire || mq.size() > 0) && k < 3000) begin
      cyc(0, 8'h00);
      k++;
    end
    check("drain", int'(on_wire || mq.size() > 0), 0);
    repeat (4 * H) cyc(0, 8'h00);
  endtask

  initial begin
    int k;
    int peak_drops;
    repeat (5) cyc(0, 8'h00);
    rst = 1'b0;

    // Idle line after reset.
    repeat (40) cyc(0, 8'h00);

    // Single byte, then back-to-back pair.
    cyc(1, 8'hA5);
    cyc(0, 8'h00);
    wait_idle();
    cyc(1, 8'h3C);
    repeat (10) cyc(0, 8'h00);
    cyc(1, 8'hF0);
    cyc(0, 8'h00);
    wait_idle();

    // Six consecutive strobes at several divider phases.
    for (int p = 0; p < 4; p++) begin
      repeat (p * 3) cyc(0, 8'h00);
      for (int i = 0; i < 6; i++) cyc(1, 8'($urandom));
      cyc(0, 8'h00);
      wait_idle();
    end

    // Random sparse traffic.
    for (int i = 0; i < 600; i++) cyc(($urandom_range(0, 7) == 0), 8'($urandom));
    cyc(0, 8'h00);
    wait_idle();

    // Continuous strobing: full FIFO with pushes landing on pop cycles, then saturation.
    for (int i = 0; i < 320; i++) cyc(1, 8'($urandom));
    cyc(0, 8'h00);
    peak_drops = drops;
    check("drops_saturated_model", int'(peak_drops == 255), 1);
    wait_idle();

    // Reset in the middle of 0xFF with two bytes queued.
    cyc(1, 8'hFF);
    cyc(1, 8'h11);
    cyc(1, 8'h22);
    cyc(0, 8'h00);
    k = 0;
    while (!(on_wire && bits_sent >= 4) && k < 500) begin
      cyc(0, 8'h00);
      k++;
    end
    check("reach_bit3", int'(on_wire && bits_sent >= 4), 1);
    check("queued_before_rst", mq.size(), 2);
    @(posedge pck0);
    #2;
    rst = 1'b1;
    #1;
    check("abort_din", ssp_din, 0);
    check("abort_frame", ssp_frame, 0);
    check("abort_clk", ssp_clk, 0);
    check("abort_level", fifo_level, 0);
    repeat (3) cyc(0, 8'h00);
    rst = 1'b0;
    repeat (100) cyc(0, 8'h00);

    // A final byte proves the block recovered from the reset.
    cyc(1, 8'h5A);
    cyc(0, 8'h00);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/hf_ssp_tx.md
# hf_ssp_tx

Serializes 8-bit HF sample/demodulator bytes from a mode block onto the SSP link toward the ARM, generating `ssp_clk`, `ssp_frame` and `ssp_din`. This is the FPGA-to-ARM direction of the serial link; the ARM-to-FPGA direction is the SPI command receiver (`spck`/`mosi`/`ncs`). The block runs in the `pck0` domain, and its outputs feed the per-mode SSP output muxes. Input bytes are buffered in a small FIFO so that ADC-rate producers never stall.

## Interface
Parameters:
- `CLK_DIV_HALF`, default 4: `pck0` cycles per `ssp_clk` half-period. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of two and ≥ 2.

Ports:
- `pck0`  in  1: block clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `tx_data`  in  8: byte to send.
- `tx_strobe`  in  1: one-cycle push of `tx_data`. There is no backpressure.
- `ssp_clk`  out  1: serial clock, free-running whenever out of reset.
- `ssp_frame`  out  1: high for exactly one `ssp_clk` period, coincident with each byte's MSB.
- `ssp_din`  out  1: serial data, MSB first.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of bytes currently queued.
- `busy`  out  1: high while a byte is on the wire or the FIFO is non-empty.

## Operation
- **Clock divider.**
  - `div_cnt` counts 0..CLK_DIV_HALF-1.
  - At the terminal count, `div_cnt` wraps and `ssp_clk` toggles.
  - A *rise event* is a terminal count while `ssp_clk`=0.
  - All shifter and frame updates occur only on the `pck0` edge of a rise event.
- **FIFO.**
  - Pointers are `$clog2(FIFO_DEPTH)+1` bits wide; full/empty are decided by the MSB compare.
  - A push is accepted when not full, or when a pop occurs in the same cycle.
  - When the FIFO is full and no pop occurs, the strobe is dropped and the contents are unchanged.
  - A push into an empty FIFO can be popped at the earliest on the next cycle. The FIFO does not write through.
- **State machine: IDLE and SHIFT.** All transitions happen on rise events.
  - IDLE, FIFO non-empty: pop, load the shifter, set `ssp_din`=bit7, set `ssp_frame`=1, set `bit_cnt`=0, go to SHIFT.
  - IDLE, FIFO empty: `ssp_din`=0, `ssp_frame`=0.
  - SHIFT, `bit_cnt`<7: shift left, drive the next bit, set `ssp_frame`=0, increment `bit_cnt`.
  - SHIFT, `bit_cnt`=7, FIFO non-empty: pop and load as from IDLE. Bytes go back to back with no gap clock.
  - SHIFT, `bit_cnt`=7, FIFO empty: go to IDLE with `ssp_din`=0 and `ssp_frame`=0.
- **Reset.** `rst` asserted mid-byte aborts the byte immediately and flushes the FIFO. There is no partial-byte resume.

## Timing
- Reset values:
  - `ssp_clk`=0, `ssp_frame`=0, `ssp_din`=0.
  - `fifo_level`=0, `busy`=0.
  - `div_cnt`=0, state=IDLE.
- Outputs change only on `ssp_clk` rising edges, in the same `pck0` cycle as the toggle. The ARM samples on the falling edge.
- One byte occupies 8 `ssp_clk` periods, i.e. 16·CLK_DIV_HALF `pck0` cycles.
- Latency from `tx_strobe` into an idle, empty block to `ssp_frame` rising:
  - minimum 1 `pck0` cycle, maximum 2·CLK_DIV_HALF cycles;
  - depends on divider phase.
- `fifo_level` updates one cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- `busy` is registered; it falls on the rise event that returns to IDLE with an empty FIFO.

## Configuration
- Macro `HF_SSP_TX_DROP_CNT_EN` enables drop accounting.
- **Defined:** adds output `drop_cnt` [7:0], an 8-bit saturating counter (stops at 255).
  - Increments on every dropped strobe.
  - Reset to 0 only by `rst`.
- **Undefined:** the port is absent, and drops are silent.
- All other behaviour is identical in both builds.

## Structure
- Shared package `hf_pkg`:
  - SSP state enum (IDLE, SHIFT);
  - `SSP_BYTE_W`=8;
  - default `CLK_DIV_HALF`.
- Sub-module `hf_byte_fifo`:
  - parameterized `FIFO_DEPTH`;
  - push/pop/full/empty/level;
  - the same-cycle pop-frees-slot rule.
- Top `hf_ssp_tx` holds the divider, the state machine and the shifter.

## Test plan
1. **Reset idle.** Release `rst`, no strobes, CLK_DIV_HALF=4 → `ssp_clk` has period 8 `pck0` cycles; `ssp_frame`/`ssp_din`=0; `busy`=0.
2. **Single byte.** Strobe 0xA5 → one frame pulse 1 `ssp_clk` wide; `ssp_din` carries 1,0,1,0,0,1,0,1 on successive rises; then idle 0.
3. **Back to back.** Strobe 0x3C, 0xF0 within one byte time → 16 contiguous bits, frame pulses exactly 8 `ssp_clk` periods apart, no gap.
4. **Overflow.** Strobe 6 bytes in 6 consecutive cycles while idle (depth 4) → the first byte is popped on the next rise (possibly after all 6 strobes); `fifo_level` peaks at 4; 1 to 2 bytes are dropped depending on divider phase; with `HF_SSP_TX_DROP_CNT_EN` defined, `drop_cnt` equals the number dropped. Separately, 300 drops saturate `drop_cnt` at 255.
5. **Push and pop together.** FIFO full, strobe on a pop cycle → byte accepted, `fifo_level` stays 4, no drop counted.
6. **Reset mid-byte.** Assert `rst` after bit 3 of 0xFF with 2 bytes queued → outputs 0 immediately; after release, `fifo_level`=0 and no frame appears.
